chrisruk_strip_rx: RTL and testbench



---
 rtl/chrisruk_strip_rx_pkg.sv | 7 +
 rtl/chrisruk_strip_rx_if.sv | 22 ++
 rtl/chrisruk_edge_sync.sv | 24 ++
 rtl/chrisruk_strip_rx.sv | 108 ++++++++++
 tb/tb_chrisruk_strip_rx.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/chrisruk_strip_rx_pkg.sv
// chrisruk_strip_rx_pkg: shared constants and state type for the LED-strip receiver.
package chrisruk_strip_rx_pkg;
    localparam int START_ZEROS_DEFAULT = 32;
    localparam int FRAME_BITS = 32;
    localparam logic [2:0] HDR = 3'b111;
    typedef enum logic [1:0] {HUNT, IDLE, PIXEL} state_t;
endpackage

// File: rtl/chrisruk_strip_rx_if.sv
// chrisruk_strip_rx_if: strip input pins and decoded-pixel outputs of the receiver.
interface chrisruk_strip_rx_if #(parameter int NUM_LEDS = 64);
    localparam int IW = NUM_LEDS > 1 ? $clog2(NUM_LEDS) : 1;
    logic          led_clk;
    logic          led_data;
    logic          pix_valid;
    logic [IW-1:0] pix_index;
    logic [4:0]    pix_bright;
    logic [7:0]    pix_blue;
    logic [7:0]    pix_green;
    logic [7:0]    pix_red;
    logic          frame_done;
    logic          frame_err;
    modport master (
        output led_clk, led_data,
        input  pix_valid, pix_index, pix_bright, pix_blue, pix_green, pix_red, frame_done, frame_err
    );
    modport slave (
        input  led_clk, led_data,
        output pix_valid, pix_index, pix_bright, pix_blue, pix_green, pix_red, frame_done, frame_err
    );
endinterface

// File: rtl/chrisruk_edge_sync.sv
// chrisruk_edge_sync: 2-flop synchronizers for a serial clock/data pair, strobing on the clock's falling edge.
module chrisruk_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic clk_in,
    input  logic data_in,
    output logic strobe,
    output logic bit_val
);
    // c[1:0] and d[1:0] are the synchronizer stages; c[2] keeps the previous synced clock level
    logic [2:0] c;
    logic [1:0] d;
    always_ff @(posedge clk) begin
        if (reset) begin
            c <= '0;
            d <= '0;
        end else begin
            c <= {c[1:0], clk_in};
            d <= {d[0], data_in};
        end
    end
    assign strobe  = c[2] & ~c[1];
    assign bit_val = d[1];
endmodule

// File: rtl/chrisruk_strip_rx.sv
// chrisruk_strip_rx: decodes the serial LED-strip stream back into indexed pixels.
module chrisruk_strip_rx
    import chrisruk_strip_rx_pkg::*;
#(
    parameter int NUM_LEDS    = 64,
    parameter int START_ZEROS = START_ZEROS_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    chrisruk_strip_rx_if.slave rx
);
    localparam int IW = NUM_LEDS > 1 ? $clog2(NUM_LEDS) : 1;
    localparam int ZW = $clog2(START_ZEROS + 1);
    localparam int BW = $clog2(FRAME_BITS + 1);
    logic                  stb, b;
    state_t                state;
    logic [ZW-1:0]         zero_cnt, zc_next;
    logic [BW-1:0]         bit_cnt;
    logic [FRAME_BITS-2:0] sh;
    logic [FRAME_BITS-1:0] word;
    logic [IW-1:0]         idx;
    logic                  hit, last;
    logic                  pix_valid, frame_done, frame_err;
    logic [IW-1:0]         pix_index;
    logic [4:0]            pix_bright;
    logic [7:0]            pix_blue, pix_green, pix_red;

    chrisruk_edge_sync u_sync (
        .clk     (clk),
        .reset   (reset),
        .clk_in  (rx.led_clk),
        .data_in (rx.led_data),
        .strobe  (stb),
        .bit_val (b)
    );

    assign zc_next = b ? '0 : (zero_cnt == ZW'(START_ZEROS) ? zero_cnt : zero_cnt + 1'b1);
    assign hit     = zc_next == ZW'(START_ZEROS);
    assign word    = {sh, b};
    assign last    = idx == IW'(NUM_LEDS - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= HUNT;
            zero_cnt   <= '0;
            bit_cnt    <= '0;
            sh         <= '0;
            idx        <= '0;
            pix_valid  <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            pix_index  <= '0;
            pix_bright <= '0;
            pix_blue   <= '0;
            pix_green  <= '0;
            pix_red    <= '0;
        end else begin
            pix_valid  <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            if (stb) begin
                zero_cnt <= zc_next;
                sh       <= word[FRAME_BITS-2:0];
                if (state == HUNT) begin
                    if (hit) state <= IDLE;
                end else if (state == IDLE) begin
                    if (b) begin
                        bit_cnt <= BW'(1);
                        state   <= PIXEL;
                    end
                end else if (hit) begin
                    // a full start-frame run inside a pixel truncates it and resyncs at once
                    frame_err <= 1'b1;
                    idx       <= '0;
                    state     <= IDLE;
                end else if (bit_cnt == BW'(FRAME_BITS - 1)) begin
                    bit_cnt <= '0;
                    if (word[31:29] != HDR) begin
                        frame_err <= 1'b1;
                        idx       <= '0;
                        state     <= HUNT;
                    end else begin
                        pix_valid  <= 1'b1;
                        pix_index  <= idx;
                        pix_bright <= word[28:24];
                        pix_blue   <= word[23:16];
                        pix_green  <= word[15:8];
                        pix_red    <= word[7:0];
                        frame_done <= last;
                        idx        <= last ? '0 : idx + 1'b1;
                        state      <= last ? HUNT : PIXEL;
                    end
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

    assign rx.pix_valid  = pix_valid;
    assign rx.frame_done = frame_done;
    assign rx.frame_err  = frame_err;
    assign rx.pix_index  = pix_index;
    assign rx.pix_bright = pix_bright;
    assign rx.pix_blue   = pix_blue;
    assign rx.pix_green  = pix_green;
    assign rx.pix_red    = pix_red;
endmodule

// File: tb/tb_chrisruk_strip_rx.sv
// tb_chrisruk_strip_rx: directed-vector bench for the LED-strip receiver.
module tb_chrisruk_strip_rx;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] wq[$];
    logic [5:0]  iq[$];
    int   err_seen = 0, dones = 0, done_nv = 0, dbl = 0;
    logic [5:0] done_idx = '0;
    logic pv = 1'b0, pe = 1'b0, pd = 1'b0;

    chrisruk_strip_rx_if #(.NUM_LEDS(64)) bus ();

    chrisruk_strip_rx #(.NUM_LEDS(64), .START_ZEROS(32)) dut (
        .clk   (clk),
        .reset (reset),
        .rx    (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.pix_valid) begin
            wq.push_back({3'b111, bus.pix_bright, bus.pix_blue, bus.pix_green, bus.pix_red});
            iq.push_back(bus.pix_index);
        end
        if (bus.frame_err) err_seen++;
        if (bus.frame_done) begin
            dones++;
            done_idx = bus.pix_index;
            if (!bus.pix_valid) done_nv++;
        end
        if ((bus.pix_valid && pv) || (bus.frame_err && pe) || (bus.frame_done && pd)) dbl++;
        pv = bus.pix_valid;
        pe = bus.frame_err;
        pd = bus.frame_done;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b, input int p);
        bus.led_data = b;
        bus.led_clk  = 1'b1;
        repeat (p / 2) @(negedge clk);
        bus.led_clk = 1'b0;
        repeat (p - p / 2) @(negedge clk);
    endtask

    task automatic send_bits(input logic [31:0] w, input int n, input int lo, input int hi);
        for (int i = 31; i > 31 - n; i--) send_bit(w[i], $urandom_range(lo, hi));
    endtask

    task automatic send_zeros(input int n, input int lo, input int hi);
        for (int i = 0; i < n; i++) send_bit(1'b0, $urandom_range(lo, hi));
    endtask

    task automatic pulse_reset();
        bus.led_clk  = 1'b0;
        bus.led_data = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic drain();
        repeat (8) @(negedge clk);
    endtask

    task automatic run_frame(input string tag, input int lo, input int hi);
        int v0, e0, d0;
        logic [31:0] exp;
        pulse_reset();
        v0 = wq.size();
        e0 = err_seen;
        d0 = dones;
        send_zeros(32, lo, hi);
        for (int i = 0; i < 64; i++) send_bits(i[0] ? 32'hF0070000 : 32'hF0000F00, 32, lo, hi);
        send_zeros(64, lo, hi);
        drain();
        check({tag, "_count"}, wq.size() - v0, 64);
        for (int i = 0; i < 64; i++) begin
            exp = i[0] ? 32'hF0070000 : 32'hF0000F00;
            if (v0 + i < wq.size()) begin
                check({tag, "_idx"}, {26'd0, iq[v0+i]}, i);
                check({tag, "_word"}, wq[v0+i], exp);
            end
        end
        check({tag, "_done"}, dones - d0, 1);
        check({tag, "_done_idx"}, {26'd0, done_idx}, 63);
        check({tag, "_err"}, err_seen - e0, 0);
    endtask

    initial begin
        int v0, e0;
        bus.led_clk  = 1'b0;
        bus.led_data = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_valid", {31'd0, bus.pix_valid}, 0);
        check("reset_flags", {30'd0, bus.frame_done, bus.frame_err}, 0);
        check("reset_fields", {bus.pix_index, bus.pix_bright, bus.pix_blue, bus.pix_green[4:0]}, 0);
        reset = 1'b0;

        // single pixel
        pulse_reset();
        v0 = wq.size();
        send_zeros(32, 4, 4);
        send_bits(32'hF0000F00, 32, 4, 4);
        drain();
        check("t1_count", wq.size() - v0, 1);
        check("t1_index", {26'd0, bus.pix_index}, 0);
        check("t1_bright", {27'd0, bus.pix_bright}, 16);
        check("t1_blue", {24'd0, bus.pix_blue}, 8'h00);
        check("t1_green", {24'd0, bus.pix_green}, 8'h0F);
        check("t1_red", {24'd0, bus.pix_red}, 8'h00);

        run_frame("t2", 4, 4);

        // bad header then recovery
        pulse_reset();
        v0 = wq.size();
        e0 = err_seen;
        send_zeros(32, 4, 4);
        send_bits(32'hB0000000, 32, 4, 4);
        drain();
        check("t3_err", err_seen - e0, 1);
        check("t3_novalid", wq.size() - v0, 0);
        send_zeros(32, 4, 4);
        send_bits(32'hF0000F00, 32, 4, 4);
        drain();
        check("t3_count", wq.size() - v0, 1);
        check("t3_index", {26'd0, bus.pix_index}, 0);
        check("t3_err_after", err_seen - e0, 1);

        // truncated frame resyncs straight to idle
        pulse_reset();
        v0 = wq.size();
        e0 = err_seen;
        send_zeros(32, 4, 5);
        for (int i = 0; i < 10; i++) send_bits(32'hF0000F00, 32, 4, 5);
        send_zeros(40, 4, 5);
        drain();
        check("t4_err", err_seen - e0, 1);
        check("t4_count", wq.size() - v0, 10);
        if (wq.size() >= v0 + 10) check("t4_idx9", {26'd0, iq[v0+9]}, 9);
        send_bits(32'hF0070000, 32, 4, 5);
        drain();
        check("t4_next_count", wq.size() - v0, 11);
        check("t4_next_idx", {26'd0, bus.pix_index}, 0);
        check("t4_next_blue", {24'd0, bus.pix_blue}, 8'h07);
        check("t4_err_after", err_seen - e0, 1);

        // reset mid-pixel
        pulse_reset();
        v0 = wq.size();
        e0 = err_seen;
        send_zeros(32, 4, 4);
        for (int i = 0; i < 5; i++) send_bits(32'hF0000F00, 32, 4, 4);
        send_bits(32'hF0070000, 17, 4, 4);
        check("t5_pre_count", wq.size() - v0, 5);
        reset = 1'b1;
        @(negedge clk);
        check("t5_rst_valid", {29'd0, bus.pix_valid, bus.frame_done, bus.frame_err}, 0);
        check("t5_rst_fields", {bus.pix_index, bus.pix_bright, bus.pix_green, bus.pix_red[4:0]}, 0);
        @(negedge clk);
        reset = 1'b0;
        send_zeros(32, 4, 4);
        send_bits(32'hF0070000, 32, 4, 4);
        drain();
        check("t5_count", wq.size() - v0, 6);
        check("t5_index", {26'd0, bus.pix_index}, 0);
        check("t5_word", {3'b111, bus.pix_bright, bus.pix_blue, bus.pix_green, bus.pix_red}, 32'hF0070000);
        check("t5_err", err_seen - e0, 0);

        // ones and a short zero run never sync
        pulse_reset();
        v0 = wq.size();
        e0 = err_seen;
        for (int i = 0; i < 5; i++) send_bit(1'b1, 4);
        send_zeros(31, 4, 4);
        send_bit(1'b1, 4);
        send_bits(32'hF0000F00, 32, 4, 4);
        drain();
        check("t6_novalid", wq.size() - v0, 0);
        check("t6_noerr", err_seen - e0, 0);

        run_frame("t6_fast", 4, 8);
        run_frame("t6_slow", 12, 20);

        check("pulse_width", dbl, 0);
        check("done_with_valid", done_nv, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
